// File: rtl/and4_sweep_checker.sv
// Exhaustive 16-vector sweep driver and response checker for the 4-input AND network.
// Drives in1..in4, compares the six responses to a golden model, counts mismatches, compacts into a MISR.
module and4_sweep_checker #(
  parameter int                PASSES     = 1,
  parameter int                SAMPLE_LAT = 0,
  parameter int                SIG_W      = 16,
  parameter logic [SIG_W-1:0]  SIG_POLY   = 16'h002D,
  parameter int                ERR_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              in1,
  output logic              in2,
  output logic              in3,
  output logic              in4,
  input  logic              n7,
  input  logic              n9,
  input  logic              n11,
  input  logic              n13,
  input  logic              n14,
  input  logic              n15,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic              first_fail_valid,
  output logic [3:0]        first_fail_vec,
  output logic [SIG_W-1:0]  signature
);

  typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_t;

  localparam logic [3:0] PASS_END  = 4'(PASSES);
  localparam logic [1:0] DRAIN_END = 2'(SAMPLE_LAT - 1);

  state_t r_state;
  state_t w_state_next;

  logic [3:0]       r_cnt;
  logic [3:0]       r_pass_cnt;
  logic [1:0]       r_drain;
  logic [3:0]       r_vec;
  logic [ERR_W-1:0] r_err;
  logic             r_ffv;
  logic [3:0]       r_ffvec;
  logic [SIG_W-1:0] r_sig;

  // Expected response and vector index, delayed to line up with the DUT latency.
  logic             r_pv [0:SAMPLE_LAT];
  logic [5:0]       r_pe [0:SAMPLE_LAT];
  logic [3:0]       r_pi [0:SAMPLE_LAT];

  logic             w_accept;
  logic             w_drive_end;
  logic             w_load;
  logic [3:0]       w_vec;
  logic [5:0]       w_exp;
  logic [5:0]       w_resp;
  logic             w_sample;
  logic             w_mismatch;
  logic [SIG_W-1:0] w_sig_next;

  assign w_accept    = start && (r_state == IDLE || r_state == DONE);
  assign w_drive_end = (r_state == DRIVE) && (r_cnt == 4'd0) && (r_pass_cnt == PASS_END);
  assign w_load      = w_accept || ((r_state == DRIVE) && !w_drive_end);
  assign w_vec       = w_accept ? 4'd0 : r_cnt;

  assign w_exp = {w_vec[2] & w_vec[3],
                  w_vec[1] & w_vec[3],
                  w_vec[1] & w_vec[2] & w_vec[3],
                  w_vec[0] & w_vec[1] & w_vec[3],
                  w_vec[0] & w_vec[2] & w_vec[3],
                  w_vec[0] & w_vec[1] & w_vec[2] & w_vec[3]};

  assign w_resp     = {n15, n14, n13, n11, n9, n7};
  assign w_sample   = r_pv[SAMPLE_LAT];
  assign w_mismatch = w_sample && (w_resp != r_pe[SAMPLE_LAT]);
  assign w_sig_next = {r_sig[SIG_W-2:0], 1'b0}
                    ^ (r_sig[SIG_W-1] ? SIG_POLY : '0)
                    ^ {{(SIG_W-6){1'b0}}, w_resp};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, DONE: if (w_accept) w_state_next = DRIVE;
      DRIVE:      if (w_drive_end) w_state_next = (SAMPLE_LAT > 0) ? DRAIN : DONE;
      DRAIN:      if (r_drain == DRAIN_END) w_state_next = DONE;
      default:    w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= 4'd0;
      r_pass_cnt <= 4'd0;
      r_drain    <= 2'd0;
      r_vec      <= 4'd0;
      r_err      <= '0;
      r_ffv      <= 1'b0;
      r_ffvec    <= 4'd0;
      r_sig      <= '0;
      for (int i = 0; i <= SAMPLE_LAT; i++) begin
        r_pv[i] <= 1'b0;
        r_pe[i] <= 6'd0;
        r_pi[i] <= 4'd0;
      end
    end else begin
      r_vec <= w_load ? w_vec : 4'd0;
      r_pv[0] <= w_load;
      r_pe[0] <= w_load ? w_exp : 6'd0;
      r_pi[0] <= w_vec;
      for (int i = 1; i <= SAMPLE_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pe[i] <= r_pe[i-1];
        r_pi[i] <= r_pi[i-1];
      end

      // Vector 0 goes out on the accepting edge, so counting resumes at 1.
      if (w_accept) begin
        r_cnt      <= 4'd1;
        r_pass_cnt <= 4'd0;
      end else if (r_state == DRIVE && !w_drive_end) begin
        r_cnt <= r_cnt + 4'd1;
        if (r_cnt == 4'd15) r_pass_cnt <= r_pass_cnt + 4'd1;
      end

      if (w_drive_end) begin
        r_drain <= 2'd0;
      end else if (r_state == DRAIN) begin
        r_drain <= r_drain + 2'd1;
      end

      if (w_accept) begin
        r_err   <= '0;
        r_ffv   <= 1'b0;
        r_ffvec <= 4'd0;
        r_sig   <= '1;
      end else if (w_sample) begin
        r_sig <= w_sig_next;
        if (w_mismatch) begin
          if (r_err != '1) r_err <= r_err + 1'b1;
          if (!r_ffv) begin
            r_ffv   <= 1'b1;
            r_ffvec <= r_pi[SAMPLE_LAT];
          end
        end
      end
    end
  end

  assign in1              = r_vec[0];
  assign in2              = r_vec[1];
  assign in3              = r_vec[2];
  assign in4              = r_vec[3];
  assign busy             = (r_state == DRIVE) || (r_state == DRAIN);
  assign done             = (r_state == DONE);
  // The count is frozen once done, so the zero test here matches the final-edge result.
  assign pass             = done && (r_err == '0);
  assign err_count        = r_err;
  assign first_fail_valid = r_ffv;
  assign first_fail_vec   = r_ffvec;
  assign signature        = r_sig;

endmodule

// File: doc/and4_sweep_checker.md
Name: and4_sweep_checker

Overview:
- Self-test harness stage for the 4-input AND-network benchmark block (outputs n7, n9, n11, n13, n14, n15).
- Sits directly upstream of that block: drives its in1..in4 with an exhaustive 16-vector sweep.
- Also consumes the block's six outputs, compares them against an internal golden model, counts mismatches and compacts responses into a MISR signature.
- Used for on-chip/bench sign-off of synthesized or mapped variants of the benchmark, including variants with pipeline registers.

Parameters:
- PASSES, 1: number of full 16-vector sweeps per run (1..15).
- SAMPLE_LAT, 0: DUT latency in clocks, from in1..in4 to the n-outputs (0..3).
- SIG_W, 16: MISR width (at least 8).
- SIG_POLY, 16'h002D: MISR feedback polynomial, low SIG_W bits (x^16 implicit).
- ERR_W, 8: width of the mismatch counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle run request.
- in1, in2, in3, in4  out  1 each  DUT stimulus, registered.
- n7, n9, n11, n13, n14, n15  in  1 each  DUT responses.
- busy  out  1  run in progress.
- done  out  1  run complete; held until the next accepted start.
- pass  out  1  done and zero mismatches.
- err_count  out  ERR_W  mismatch count, saturating.
- first_fail_valid  out  1  at least one mismatch recorded.
- first_fail_vec  out  4  vector index {in4,in3,in2,in1} of the first mismatch.
- signature  out  SIG_W  MISR value.

Behaviour:
- Reset, asynchronous: all outputs 0, state IDLE, pattern counter 0, expected-value pipeline cleared.
- Reset mid-run aborts immediately. No partial result is retained.
- FSM states: IDLE, DRIVE, DRAIN, DONE.
- IDLE or DONE with start=1 at edge E0:
  - go to DRIVE; busy=1; done=0; pass=0;
  - err_count=0; first_fail_valid=0; first_fail_vec=0;
  - signature = all ones; cnt=0.
- start is ignored while busy.
- DRIVE:
  - in1 = cnt[0], in2 = cnt[1], in3 = cnt[2], in4 = cnt[3].
  - cnt increments every clock and wraps 15 -> 0; pass counter increments on each wrap.
  - After 16*PASSES vectors: go to DRAIN if SAMPLE_LAT>0, else DONE. in1..in4 return to 0.
- DRAIN lasts exactly SAMPLE_LAT cycles, then DONE.
- Golden model, with a=in1, b=in2, c=in3, d=in4 as driven:
  - e7 = a&b&c&d
  - e9 = a&c&d
  - e11 = a&b&d
  - e13 = b&c&d
  - e14 = b&d
  - e15 = c&d
- Response vector R = {n15, n14, n13, n11, n9, n7} (bit 5..0). Expected vector E uses the same order.
- E and the vector index travel through a (SAMPLE_LAT+1)-deep valid-tagged pipeline.
- Vector k, driven in the cycle after E(k), is sampled at edge E(k+1+SAMPLE_LAT).
- On each valid sample:
  - if R != E: err_count += 1, saturating at all ones. If first_fail_valid=0, capture the index and set first_fail_valid.
  - signature_next = (signature << 1) ^ (signature[SIG_W-1] ? SIG_POLY : 0) ^ zero-extend(R).
- Last sample at edge E(16*PASSES + SAMPLE_LAT). At that same edge: busy=0, done=1, pass = (err_count_next == 0).
- Run length is deterministic: busy is high for exactly 16*PASSES + SAMPLE_LAT cycles.
- A start in the same cycle as the final sample is ignored (still busy).
- Multi-bit mismatch on one vector counts once.

Test Plan:
1. Ideal combinational DUT model, PASSES=1, SAMPLE_LAT=0, start at E0 -> busy high 16 cycles, done at E16, pass=1, err_count=0, signature equals the bench MISR reference.
2. n15 stuck-at-0 -> mismatches at vectors 12..15; err_count=4; first_fail_vec=12; pass=0.
3. n7 stuck-at-1, PASSES=2 -> err_count=30, first_fail_vec=0; signature differs from scenario 1.
4. DUT with 2 pipeline registers, SAMPLE_LAT=2 -> pass=1; done at E18. Same DUT with SAMPLE_LAT=0 -> err_count nonzero.
5. start pulsed at E5 during a run -> ignored, done still at E16. start pulsed while done=1 -> outputs cleared and a new run begins.
6. rst_n low at vector 7 (asynchronous, mid-cycle) -> all outputs 0 immediately. A subsequent start -> full 16-vector run, pass=1.
